// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one synchronous memory between the fetch and load/store ports
//
// Purpose:
//   Serialises instruction-fetch and data accesses onto a single-ported memory.
//   Data has priority, but a fetch is forced after STARVE_LIMIT consecutive data
//   grants made while it was waiting. Every access is bounded by a BUSY-cycle
//   watchdog (TIMEOUT, 0 disables). Each access runs IDLE -> BUSY -> RESP.
//
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   inst_req/addr -> inst_rdata/ready fetch port (ready is a one-cycle pulse)
//   data_req/we/addr/sel/wdata        load/store port
//   data_rdata/data_ready             load data and one-cycle completion pulse
//   bus_err                           pulses with a ready whose access timed out
//   stallreq_if, stallreq_mem         combinational stall requests to the cpu
//   mem_ce/we/addr/sel/wdata          registered memory request
//   mem_rdata, mem_ready              memory response, honoured only in BUSY
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 16,
  localparam int SEL_W       = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic [DATA_W-1:0] inst_rdata,
  output logic              inst_ready,
  input  logic              data_req,
  input  logic              data_we,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [SEL_W-1:0]  data_sel,
  input  logic [DATA_W-1:0] data_wdata,
  output logic [DATA_W-1:0] data_rdata,
  output logic              data_ready,
  output logic              bus_err,
  output logic              stallreq_if,
  output logic              stallreq_mem,
  output logic              mem_ce,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [SEL_W-1:0]  mem_sel,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam logic [3:0] STREAK_MAX = 4'(STARVE_LIMIT);
  // Timer holds the number of BUSY cycles already elapsed, so the abort fires
  // in the TIMEOUT-th BUSY cycle.
  localparam logic [7:0] TIMER_LAST = (TIMEOUT == 0) ? 8'd0 : 8'(TIMEOUT - 1);

  state_t              state_q, state_d;
  logic                port_is_data_q, port_is_data_d;
  logic [3:0]          streak_q, streak_d;
  logic [7:0]          timer_q, timer_d;
  logic                cancel_q, cancel_d;
  logic                mem_ce_d, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_d;
  logic [SEL_W-1:0]    mem_sel_d;
  logic [DATA_W-1:0]   mem_wdata_d;
  logic                inst_ready_d, data_ready_d, bus_err_d;
  logic [DATA_W-1:0]   inst_rdata_d, data_rdata_d;
  logic                grant_data, granted_req, cancel_now, timed_out;
  logic [DATA_W-1:0]   rdata_sel;

  assign stallreq_if  = inst_req & ~inst_ready;
  assign stallreq_mem = data_req & ~data_ready;

  always_comb begin
    state_d        = state_q;
    port_is_data_d = port_is_data_q;
    streak_d       = streak_q;
    timer_d        = timer_q;
    cancel_d       = cancel_q;
    mem_ce_d       = mem_ce;
    mem_we_d       = mem_we;
    mem_addr_d     = mem_addr;
    mem_sel_d      = mem_sel;
    mem_wdata_d    = mem_wdata;
    inst_ready_d   = 1'b0;
    data_ready_d   = 1'b0;
    bus_err_d      = 1'b0;
    inst_rdata_d   = '0;
    data_rdata_d   = '0;
    grant_data     = 1'b0;
    granted_req    = 1'b0;
    cancel_now     = 1'b0;
    timed_out      = 1'b0;
    rdata_sel      = '0;

    case (state_q)
      IDLE: begin
        timer_d    = '0;
        cancel_d   = 1'b0;
        grant_data = data_req & ~(inst_req & (streak_q == STREAK_MAX));
        if (grant_data) begin
          state_d        = BUSY;
          port_is_data_d = 1'b1;
          mem_ce_d       = 1'b1;
          mem_we_d       = data_we;
          mem_addr_d     = data_addr;
          mem_sel_d      = data_sel;
          mem_wdata_d    = data_wdata;
          // Streak only grows while a fetch is actually being held off.
          if (!inst_req)
            streak_d = '0;
          else if (streak_q != STREAK_MAX)
            streak_d = streak_q + 4'd1;
        end else if (inst_req) begin
          state_d        = BUSY;
          port_is_data_d = 1'b0;
          mem_ce_d       = 1'b1;
          mem_we_d       = 1'b0;
          mem_addr_d     = inst_addr;
          mem_sel_d      = {SEL_W{1'b1}};
          mem_wdata_d    = '0;
          streak_d       = '0;
        end else begin
          streak_d = '0;
        end
      end

      BUSY: begin
        // A requester that lets go of req at any point loses its ready pulse,
        // but the memory access itself still runs to completion.
        granted_req = port_is_data_q ? data_req : inst_req;
        cancel_now  = cancel_q | ~granted_req;
        cancel_d    = cancel_now;
        timed_out   = (TIMEOUT != 0) && (timer_q == TIMER_LAST);
        if (mem_ready || timed_out) begin
          state_d   = RESP;
          mem_ce_d  = 1'b0;
          mem_we_d  = 1'b0;
          rdata_sel = (mem_ready && !mem_we) ? mem_rdata : '0;
          bus_err_d = ~mem_ready & ~cancel_now;
          if (port_is_data_q) begin
            data_ready_d = ~cancel_now;
            data_rdata_d = rdata_sel;
          end else begin
            inst_ready_d = ~cancel_now;
            inst_rdata_d = rdata_sel;
          end
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end

      RESP: begin
        // Requests are deliberately not sampled here so a req still held
        // during the ready pulse is not issued a second time.
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      port_is_data_q <= 1'b0;
      streak_q       <= '0;
      timer_q        <= '0;
      cancel_q       <= 1'b0;
      mem_ce         <= 1'b0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_sel        <= '0;
      mem_wdata      <= '0;
      inst_ready     <= 1'b0;
      data_ready     <= 1'b0;
      bus_err        <= 1'b0;
      inst_rdata     <= '0;
      data_rdata     <= '0;
    end else begin
      state_q        <= state_d;
      port_is_data_q <= port_is_data_d;
      streak_q       <= streak_d;
      timer_q        <= timer_d;
      cancel_q       <= cancel_d;
      mem_ce         <= mem_ce_d;
      mem_we         <= mem_we_d;
      mem_addr       <= mem_addr_d;
      mem_sel        <= mem_sel_d;
      mem_wdata      <= mem_wdata_d;
      inst_ready     <= inst_ready_d;
      data_ready     <= data_ready_d;
      bus_err        <= bus_err_d;
      inst_rdata     <= inst_rdata_d;
      data_rdata     <= data_rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
  localparam int LIM = 4;
  localparam int TO  = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        inst_req, data_req, data_we;
  logic [31:0] inst_addr, data_addr, data_wdata;
  logic [3:0]  data_sel;
  logic [31:0] inst_rdata, data_rdata;
  logic        inst_ready, data_ready, bus_err, stallreq_if, stallreq_mem;
  logic        mem_ce, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_sel;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(LIM), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata), .inst_ready(inst_ready),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr), .data_sel(data_sel),
    .data_wdata(data_wdata), .data_rdata(data_rdata), .data_ready(data_ready),
    .bus_err(bus_err), .stallreq_if(stallreq_if), .stallreq_mem(stallreq_mem),
    .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr), .mem_sel(mem_sel),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [31:0] mem_arr [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  int wait_cfg = 0;
  bit never_ready = 1'b0;
  bit rand_wait = 1'b0;
  int access_cnt = 0;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (sel[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] rd(input logic [31:0] a);
    return mem_arr.exists(a) ? mem_arr[a] : 32'h0;
  endfunction

  function automatic logic [31:0] inst_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  // Memory responder: wait states counted from the first BUSY cycle; mem_ready
  // toggles randomly while mem_ce is low, which the arbiter must ignore.
  initial begin
    int busy_cnt;
    int cur_wait;
    busy_cnt = 0;
    cur_wait = 0;
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (mem_ce === 1'b1) begin
        busy_cnt++;
        if (busy_cnt == 1) begin
          access_cnt++;
          cur_wait = rand_wait ? int'($urandom_range(0, 3)) : wait_cfg;
        end
        if (!never_ready && busy_cnt > cur_wait) begin
          mem_ready = 1'b1;
          if (mem_we) begin
            mem_arr[mem_addr] = merge(rd(mem_addr), mem_wdata, mem_sel);
            mem_rdata = $urandom;
          end else begin
            mem_rdata = rd(mem_addr);
          end
        end else begin
          mem_ready = 1'b0;
          mem_rdata = $urandom;
        end
      end else begin
        busy_cnt = 0;
        mem_ready = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic data_access(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                             input logic [31:0] wd, output bit got, output logic [31:0] rdata,
                             output logic err, output int busy);
    data_we = we; data_addr = addr; data_sel = sel; data_wdata = wd; data_req = 1'b1;
    got = 1'b0; rdata = 32'h0; err = 1'b0; busy = 0;
    for (int c = 0; c < 100 && !got; c++) begin
      @(negedge clk);
      if (mem_ce === 1'b1) busy++;
      if (data_ready === 1'b1) begin
        got = 1'b1; rdata = data_rdata; err = bus_err;
      end
    end
    data_req = 1'b0;
  endtask

  task automatic test_reset();
    inst_req = 1'b1; data_req = 1'b0;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if ({mem_ce, mem_we, inst_ready, data_ready, bus_err} !== 5'b0) begin
      failures++; $display("FAIL reset_ctrl got=%b exp=00000", {mem_ce, mem_we, inst_ready, data_ready, bus_err}); end
    checks++; if (mem_addr !== 32'h0) begin failures++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); end
    checks++; if (mem_sel !== 4'h0) begin failures++; $display("FAIL reset_mem_sel got=%h exp=0", mem_sel); end
    checks++; if (mem_wdata !== 32'h0) begin failures++; $display("FAIL reset_mem_wdata got=%h exp=0", mem_wdata); end
    checks++; if ({inst_rdata, data_rdata} !== 64'h0) begin
      failures++; $display("FAIL reset_rdata got=%h/%h exp=0/0", inst_rdata, data_rdata); end
    checks++; if (stallreq_if !== 1'b1) begin failures++; $display("FAIL reset_stallreq_if got=%b exp=1", stallreq_if); end
    checks++; if (stallreq_mem !== 1'b0) begin failures++; $display("FAIL reset_stallreq_mem got=%b exp=0", stallreq_mem); end
    inst_req = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (mem_ce !== 1'b0) begin failures++; $display("FAIL reset_idle_ce got=%b exp=0", mem_ce); end
  endtask

  task automatic test_fetch_latency();
    logic [3:0] exp_ce, exp_rdy;
    exp_ce = 4'b1001;
    exp_rdy = 4'b0010;
    mem_arr[32'h0] = 32'h3401_1100;
    wait_cfg = 0; never_ready = 1'b0; rand_wait = 1'b0;
    inst_addr = 32'h0; inst_req = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      checks++; if (mem_ce !== exp_ce[c-1]) begin
        failures++; $display("FAIL fetch_mem_ce cycle=%0d got=%b exp=%b", c, mem_ce, exp_ce[c-1]); end
      checks++; if (inst_ready !== exp_rdy[c-1]) begin
        failures++; $display("FAIL fetch_ready cycle=%0d got=%b exp=%b", c, inst_ready, exp_rdy[c-1]); end
      if (c == 1) begin
        checks++; if ({mem_we, mem_sel, mem_addr} !== {1'b0, 4'hF, 32'h0}) begin
          failures++; $display("FAIL fetch_req got we=%b sel=%h addr=%h exp 0/f/0", mem_we, mem_sel, mem_addr); end
        checks++; if (stallreq_if !== 1'b1) begin failures++; $display("FAIL fetch_stall_busy got=%b exp=1", stallreq_if); end
      end
      if (c == 2) begin
        checks++; if (inst_rdata !== 32'h3401_1100) begin
          failures++; $display("FAIL fetch_rdata got=%h exp=34011100", inst_rdata); end
        checks++; if (stallreq_if !== 1'b0) begin failures++; $display("FAIL fetch_stall_ready got=%b exp=0", stallreq_if); end
      end
    end
    inst_req = 1'b0;
    for (int c = 5; c <= 7; c++) begin
      @(negedge clk);
      checks++; if ({inst_ready, mem_ce} !== 2'b00) begin
        failures++; $display("FAIL fetch_drop cycle=%0d got ready=%b ce=%b exp 0/0", c, inst_ready, mem_ce); end
    end
  endtask

  task automatic test_starvation();
    bit is_data[$];
    int n_irdy, n_drdy, n_if_low;
    logic prev_ce;
    n_irdy = 0; n_drdy = 0; n_if_low = 0; prev_ce = 1'b0;
    mem_arr[32'h100] = 32'hC0DE_0100;
    mem_arr[32'h200] = 32'hDA7A_0200;
    wait_cfg = 2;
    inst_addr = 32'h100; data_addr = 32'h200; data_we = 1'b0; data_sel = 4'hF; data_wdata = 32'h0;
    inst_req = 1'b1; data_req = 1'b1;
    for (int c = 0; c < 300 && is_data.size() < 10; c++) begin
      @(negedge clk);
      if (mem_ce && !prev_ce) is_data.push_back(mem_addr == 32'h200);
      prev_ce = mem_ce;
      if (stallreq_if === 1'b0) n_if_low++;
      if (inst_ready === 1'b1) begin
        n_irdy++;
        checks++; if (inst_rdata !== 32'hC0DE_0100) begin
          failures++; $display("FAIL starve_inst_rdata got=%h exp=c0de0100", inst_rdata); end
      end
      if (data_ready === 1'b1) begin
        n_drdy++;
        checks++; if (data_rdata !== 32'hDA7A_0200) begin
          failures++; $display("FAIL starve_data_rdata got=%h exp=da7a0200", data_rdata); end
      end
    end
    inst_req = 1'b0; data_req = 1'b0;
    checks++; if (is_data.size() != 10) begin
      failures++; $display("FAIL starve_grants got=%0d exp=10", is_data.size()); end
    for (int i = 0; i < is_data.size(); i++) begin
      checks++; if (is_data[i] != ((i % (LIM + 1)) != LIM)) begin
        failures++; $display("FAIL starve_order grant=%0d got_data=%0b exp_data=%0b", i, is_data[i], (i % (LIM + 1)) != LIM); end
    end
    checks++; if (n_irdy != 1 || n_drdy != 8) begin
      failures++; $display("FAIL starve_readies got=%0d/%0d exp=1/8", n_irdy, n_drdy); end
    checks++; if (n_if_low != 1) begin
      failures++; $display("FAIL starve_stallreq_if_low got=%0d exp=1", n_if_low); end
    repeat (6) @(negedge clk);
  endtask

  task automatic test_store();
    int busy, n_rdy;
    bit got;
    logic [31:0] rdata;
    logic err;
    mem_arr[32'h10] = 32'h1122_3344;
    wait_cfg = 2;
    data_we = 1'b1; data_addr = 32'h10; data_sel = 4'b0011; data_wdata = 32'hAABB_CCDD; data_req = 1'b1;
    busy = 0; got = 1'b0;
    for (int c = 0; c < 50 && !got; c++) begin
      @(negedge clk);
      if (mem_ce === 1'b1) begin
        busy++;
        checks++; if ({mem_we, mem_sel, mem_addr, mem_wdata} !== {1'b1, 4'b0011, 32'h10, 32'hAABB_CCDD}) begin
          failures++; $display("FAIL store_busy got we=%b sel=%b addr=%h wd=%h", mem_we, mem_sel, mem_addr, mem_wdata); end
        checks++; if (stallreq_mem !== 1'b1) begin failures++; $display("FAIL store_stall got=%b exp=1", stallreq_mem); end
      end
      if (data_ready === 1'b1) begin
        got = 1'b1;
        checks++; if ({data_rdata, bus_err} !== 33'h0) begin
          failures++; $display("FAIL store_resp got rdata=%h err=%b exp 0/0", data_rdata, bus_err); end
      end
    end
    data_req = 1'b0;
    checks++; if (!got || busy != 3) begin failures++; $display("FAIL store_done got=%0b busy=%0d exp 1/3", got, busy); end
    @(negedge clk);
    checks++; if (data_ready !== 1'b0) begin failures++; $display("FAIL store_pulse got=%b exp=0", data_ready); end
    checks++; if (rd(32'h10) !== 32'h1122_CCDD) begin failures++; $display("FAIL store_mem got=%h exp=1122ccdd", rd(32'h10)); end
    data_access(1'b0, 32'h10, 4'hF, 32'h0, got, rdata, err, busy);
    checks++; if (!got || rdata !== 32'h1122_CCDD) begin
      failures++; $display("FAIL store_readback got=%0b/%h exp 1/1122ccdd", got, rdata); end
    mem_arr[32'h14] = 32'h0;
    data_we = 1'b1; data_addr = 32'h14; data_sel = 4'b1100; data_wdata = 32'h5566_7788; data_req = 1'b1;
    for (int c = 0; c < 20 && mem_ce !== 1'b1; c++) @(negedge clk);
    data_req = 1'b0;
    n_rdy = 0;
    repeat (8) begin
      @(negedge clk);
      if (data_ready === 1'b1) n_rdy++;
    end
    checks++; if (n_rdy != 0) begin failures++; $display("FAIL store_drop_ready got=%0d exp=0", n_rdy); end
    checks++; if (rd(32'h14) !== 32'h5566_0000) begin failures++; $display("FAIL store_drop_mem got=%h exp=55660000", rd(32'h14)); end
  endtask

  task automatic test_timeout();
    int busy;
    bit got;
    logic [31:0] rdata;
    logic err;
    never_ready = 1'b1;
    data_access(1'b0, 32'h200, 4'hF, 32'h0, got, rdata, err, busy);
    never_ready = 1'b0;
    checks++; if (!got || busy != TO) begin failures++; $display("FAIL timeout_busy got=%0b/%0d exp 1/%0d", got, busy, TO); end
    checks++; if ({err, rdata} !== {1'b1, 32'h0}) begin failures++; $display("FAIL timeout_err got err=%b rdata=%h exp 1/0", err, rdata); end
    @(negedge clk);
    checks++; if ({data_ready, bus_err} !== 2'b00) begin
      failures++; $display("FAIL timeout_pulse got=%b%b exp=00", data_ready, bus_err); end
  endtask

  task automatic test_reset_mid_busy();
    bit got;
    never_ready = 1'b1;
    data_we = 1'b0; data_addr = 32'h200; data_sel = 4'hF; data_req = 1'b1;
    for (int c = 0; c < 20 && mem_ce !== 1'b1; c++) @(negedge clk);
    checks++; if (mem_ce !== 1'b1) begin failures++; $display("FAIL midrst_start got=%b exp=1", mem_ce); end
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if ({mem_ce, mem_we, inst_ready, data_ready, bus_err, mem_addr, data_rdata} !== 69'h0) begin
      failures++; $display("FAIL midrst_async got ce=%b addr=%h rdy=%b exp all 0", mem_ce, mem_addr, data_ready); end
    checks++; if (stallreq_mem !== 1'b1) begin failures++; $display("FAIL midrst_stall got=%b exp=1", stallreq_mem); end
    @(negedge clk);
    never_ready = 1'b0; wait_cfg = 1;
    checks++; if ({data_ready, mem_ce} !== 2'b00) begin failures++; $display("FAIL midrst_hold got=%b%b exp=00", data_ready, mem_ce); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if ({mem_ce, mem_addr, data_ready} !== {1'b1, 32'h200, 1'b0}) begin
      failures++; $display("FAIL midrst_regrant got ce=%b addr=%h rdy=%b exp 1/200/0", mem_ce, mem_addr, data_ready); end
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (data_ready === 1'b1) begin
        got = 1'b1;
        checks++; if (data_rdata !== 32'hDA7A_0200) begin
          failures++; $display("FAIL midrst_rdata got=%h exp=da7a0200", data_rdata); end
      end
    end
    data_req = 1'b0;
    checks++; if (!got) begin failures++; $display("FAIL midrst_done got=0 exp=1"); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_random();
    for (int i = 0; i < 16; i++) mem_arr[32'h1000 + 32'(4 * i)] = inst_word(32'h1000 + 32'(4 * i));
    for (int i = 0; i < 8; i++) begin
      ref_mem[32'h2000 + 32'(4 * i)] = $urandom;
      mem_arr[32'h2000 + 32'(4 * i)] = ref_mem[32'h2000 + 32'(4 * i)];
    end
    rand_wait = 1'b1;
    access_cnt = 0;
    fork
      begin
        logic [31:0] a;
        bit got;
        for (int i = 0; i < 40; i++) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          a = 32'h1000 + 32'(4 * $urandom_range(0, 15));
          inst_addr = a; inst_req = 1'b1; got = 1'b0;
          for (int c = 0; c < 300 && !got; c++) begin
            @(negedge clk);
            if (inst_ready === 1'b1) begin
              got = 1'b1;
              checks++; if ({bus_err, inst_rdata} !== {1'b0, inst_word(a)}) begin
                failures++; $display("FAIL rand_inst addr=%h got=%h err=%b exp=%h", a, inst_rdata, bus_err, inst_word(a)); end
            end
          end
          inst_req = 1'b0;
          checks++; if (!got) begin failures++; $display("FAIL rand_inst_timeout txn=%0d got=0 exp=1", i); end
        end
      end
      begin
        logic [31:0] a, wd, exp;
        logic [3:0] sel;
        logic we;
        bit got;
        for (int i = 0; i < 40; i++) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          a = 32'h2000 + 32'(4 * $urandom_range(0, 7));
          we = 1'($urandom_range(0, 1));
          sel = 4'($urandom_range(1, 15));
          wd = $urandom;
          exp = we ? 32'h0 : ref_mem[a];
          data_addr = a; data_we = we; data_sel = sel; data_wdata = wd; data_req = 1'b1; got = 1'b0;
          for (int c = 0; c < 300 && !got; c++) begin
            @(negedge clk);
            if (data_ready === 1'b1) begin
              got = 1'b1;
              checks++; if ({bus_err, data_rdata} !== {1'b0, exp}) begin
                failures++; $display("FAIL rand_data addr=%h we=%b got=%h err=%b exp=%h", a, we, data_rdata, bus_err, exp); end
              if (we) ref_mem[a] = merge(ref_mem[a], wd, sel);
            end
          end
          data_req = 1'b0;
          checks++; if (!got) begin failures++; $display("FAIL rand_data_timeout txn=%0d got=0 exp=1", i); end
        end
      end
    join
    repeat (4) @(negedge clk);
    rand_wait = 1'b0;
    checks++; if (access_cnt != 80) begin failures++; $display("FAIL rand_access_count got=%0d exp=80", access_cnt); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (rd(32'h2000 + 32'(4 * i)) !== ref_mem[32'h2000 + 32'(4 * i)]) begin
        failures++; $display("FAIL rand_mem word=%0d got=%h exp=%h", i, rd(32'h2000 + 32'(4 * i)), ref_mem[32'h2000 + 32'(4 * i)]); end
    end
  endtask

  initial begin
    inst_req = 1'b0; inst_addr = 32'h0;
    data_req = 1'b0; data_we = 1'b0; data_addr = 32'h0; data_sel = 4'h0; data_wdata = 32'h0;
    test_reset();
    test_fetch_latency();
    test_starvation();
    test_store();
    test_timeout();
    test_reset_mid_busy();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
